nw_traceback: RTL and testbench

NW_TRACEBACK -- requirements
Module: nw_traceback

---
 rtl/nw_traceback.sv | 180 ++++++++++++++++++
 tb/tb_nw_traceback.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nw_traceback.sv
// nw_traceback: walks a Needleman-Wunsch direction grid from the bottom-right
// cell back to (0,0), streaming each visited {x,y} out on a write port and
// keeping a copy in a small buffer that can be read back at any time.
// Optional feature macro: NW_TRACEBACK_DIR_CHECK_EN (flags code 2'b11 as an
// illegal direction and ends the walk early with error raised).
module nw_traceback #(
  parameter int         LENGTH      = 10,
  parameter int         CORD_LENGTH = 8,
  parameter int         ADDR_WIDTH  = 5,
  parameter logic [1:0] TOP_DIR     = 2'b00,
  parameter logic [1:0] LEFT_DIR    = 2'b01,
  parameter logic [1:0] CORNER_DIR  = 2'b10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2*LENGTH*LENGTH-1:0]   directions,
  input  logic                         grid_valid,
  output logic                         wen,
  output logic [ADDR_WIDTH-1:0]        waddr,
  output logic [2*CORD_LENGTH-1:0]     wdata,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [2*CORD_LENGTH-1:0]     rd_data,
  output logic [ADDR_WIDTH:0]          path_len,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int DEPTH = 2*LENGTH-1;
  localparam logic [CORD_LENGTH-1:0] LAST = CORD_LENGTH'(LENGTH-1);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                      state_q;
  logic [CORD_LENGTH-1:0]      x_q, y_q, x_d, y_d;
  logic [ADDR_WIDTH-1:0]       cnt_q;
  logic                        wen_q;
  logic [ADDR_WIDTH-1:0]       waddr_q;
  logic [2*CORD_LENGTH-1:0]    wdata_q;
  logic [2*CORD_LENGTH-1:0]    rdData_q;
  logic [ADDR_WIDTH:0]         pathLen_q;
  logic                        done_q;
  logic [2*CORD_LENGTH-1:0]    buf_q [DEPTH];
  logic                        dirBad;
  logic                        atOrigin;
  logic [1:0]                  curDir;
  int                          cellIdx;

  assign cellIdx  = int'(y_q) * LENGTH + int'(x_q);
  assign curDir   = directions[cellIdx*2 +: 2];
  assign atOrigin = (x_q == '0) && (y_q == '0);

  // Next coordinate: edges of the grid force a straight walk, otherwise follow the cell code
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    dirBad = 1'b0;
    if (atOrigin) begin
      x_d = x_q;
    end else if (y_q == '0) begin
      x_d = x_q - CORD_LENGTH'(1);
    end else if (x_q == '0) begin
      y_d = y_q - CORD_LENGTH'(1);
    end else begin
      case (curDir)
        TOP_DIR:    y_d = y_q - CORD_LENGTH'(1);
        LEFT_DIR:   x_d = x_q - CORD_LENGTH'(1);
        CORNER_DIR: begin
          x_d = x_q - CORD_LENGTH'(1);
          y_d = y_q - CORD_LENGTH'(1);
        end
        default: begin
`ifdef NW_TRACEBACK_DIR_CHECK_EN
          dirBad = 1'b1;
`else
          x_d = x_q - CORD_LENGTH'(1);
          y_d = y_q - CORD_LENGTH'(1);
`endif
        end
      endcase
    end
  end

`ifdef NW_TRACEBACK_DIR_CHECK_EN
  logic error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Control FSM with registered write-port, length and done outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= LAST;
      y_q       <= LAST;
      cnt_q     <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pathLen_q <= '0;
      done_q    <= 1'b0;
`ifdef NW_TRACEBACK_DIR_CHECK_EN
      error_q   <= 1'b0;
`endif
    end else begin
      wen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grid_valid) begin
            state_q   <= WALK;
            x_q       <= LAST;
            y_q       <= LAST;
            cnt_q     <= '0;
            pathLen_q <= '0;
`ifdef NW_TRACEBACK_DIR_CHECK_EN
            error_q   <= 1'b0;
`endif
          end
        end
        WALK: begin
          if (dirBad) begin
            state_q   <= DONE;
            pathLen_q <= {1'b0, cnt_q};
`ifdef NW_TRACEBACK_DIR_CHECK_EN
            error_q   <= 1'b1;
`endif
          end else begin
            wen_q   <= 1'b1;
            waddr_q <= cnt_q;
            wdata_q <= {x_q, y_q};
            cnt_q   <= cnt_q + ADDR_WIDTH'(1);
            x_q     <= x_d;
            y_q     <= y_d;
            if (atOrigin) begin
              state_q   <= DONE;
              pathLen_q <= {1'b0, cnt_q} + (ADDR_WIDTH+1)'(1);
            end
          end
        end
        DONE: begin
          if (!done_q) begin
            done_q <= 1'b1;
          end else if (!grid_valid) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Path buffer: keeps the last walk across reset, only the length gates read-back
  always_ff @(posedge clk) begin
    if (state_q == WALK && !dirBad && !reset) begin
      buf_q[cnt_q] <= {x_q, y_q};
    end
  end

  // Registered read port returning zero beyond the stored path
  always_ff @(posedge clk) begin
    if (reset) begin
      rdData_q <= '0;
    end else if ({1'b0, rd_addr} < pathLen_q) begin
      rdData_q <= buf_q[rd_addr];
    end else begin
      rdData_q <= '0;
    end
  end

  assign wen      = wen_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign rd_data  = rdData_q;
  assign path_len = pathLen_q;
  assign busy     = (state_q == WALK);
  assign done     = done_q;

endmodule

// File: tb/tb_nw_traceback.sv
// Self-checking bench for nw_traceback on a 4x4 grid, comparing against a
// coordinate-walking reference model.
module tb_nw_traceback;

  localparam int L  = 4;
  localparam int CL = 8;
  localparam int AW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [2*L*L-1:0]  directions;
  logic              grid_valid;
  logic              wen;
  logic [AW-1:0]     waddr;
  logic [2*CL-1:0]   wdata;
  logic [AW-1:0]     rd_addr;
  logic [2*CL-1:0]   rd_data;
  logic [AW:0]       path_len;
  logic              busy;
  logic              done;
  logic              error;

  int errors = 0;
  int checks = 0;

  logic [2*CL-1:0] expPath [0:15];
  int              expLen;
  bit              expErr;

  nw_traceback #(
    .LENGTH(L), .CORD_LENGTH(CL), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .directions(directions), .grid_valid(grid_valid),
    .wen(wen), .waddr(waddr), .wdata(wdata), .rd_addr(rd_addr), .rd_data(rd_data),
    .path_len(path_len), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [2*L*L-1:0] fillGrid(input logic [1:0] c);
    logic [2*L*L-1:0] g;
    for (int i = 0; i < L*L; i++) g[i*2 +: 2] = c;
    return g;
  endfunction

  function automatic logic [2*L*L-1:0] randGrid();
    logic [2*L*L-1:0] g;
    for (int i = 0; i < L*L; i++) g[i*2 +: 2] = 2'($urandom_range(0, 3));
    return g;
  endfunction

  // Reference: follow the traceback rules on plain integer coordinates
  task automatic modelWalk(input logic [2*L*L-1:0] grid);
    int x = L-1;
    int y = L-1;
    logic [1:0] c;
    expLen = 0;
    expErr = 1'b0;
    for (int s = 0; s < 2*L; s++) begin
      c = 2'b00;
      if (x > 0 && y > 0) c = grid[(y*L + x)*2 +: 2];
`ifdef NW_TRACEBACK_DIR_CHECK_EN
      if (x > 0 && y > 0 && c == 2'b11) begin
        expErr = 1'b1;
        break;
      end
`endif
      expPath[expLen] = {CL'(x), CL'(y)};
      expLen++;
      if (x == 0 && y == 0) break;
      if (y == 0) x--;
      else if (x == 0) y--;
      else if (c == 2'b00) y--;
      else if (c == 2'b01) x--;
      else begin x--; y--; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; grid_valid = 1'b0; rd_addr = '0; directions = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wen, waddr, wdata, rd_data, path_len, busy, done, error} !== '0)
      $display("[TB] FAIL reset_state: got wen=%b waddr=%0d wdata=%h rd=%h len=%0d busy=%b done=%b err=%b, expected all 0",
               wen, waddr, wdata, rd_data, path_len, busy, done, error);
    reset = 1'b0;
  endtask

  // Raise grid_valid and check every write, the length, done timing and error
  task automatic runWalk(input logic [2*L*L-1:0] grid, input string name);
    modelWalk(grid);
    directions = grid;
    grid_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wen !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_start: got wen=%b busy=%b, expected wen=0 busy=1", name, wen, busy);
    end
    for (int i = 0; i < expLen; i++) begin
      @(posedge clk); #1;
      checks++;
      if (wen !== 1'b1 || waddr !== AW'(i) || wdata !== expPath[i] || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s_entry%0d: got wen=%b waddr=%0d wdata=%h done=%b, expected wen=1 waddr=%0d wdata=%h done=0",
                 name, i, wen, waddr, wdata, done, i, expPath[i]);
      end
    end
    if (expErr) begin
      @(posedge clk); #1;
      checks++;
      if (wen !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s_errgap: got wen=%b done=%b, expected wen=0 done=0", name, wen, done);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (wen !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || path_len !== (AW+1)'(expLen) || error !== expErr) begin
      errors++;
      $display("[TB] FAIL %s_done: got wen=%b done=%b busy=%b len=%0d err=%b, expected wen=0 done=1 busy=0 len=%0d err=%b",
               name, wen, done, busy, path_len, error, expLen, expErr);
    end
  endtask

  task automatic dropGrid(input string name);
    grid_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_drop: got done=%b busy=%b wen=%b, expected 0 0 0", name, done, busy, wen);
    end
  endtask

  task automatic checkReads(input string name);
    logic [2*CL-1:0] exp;
    for (int i = 0; i < (1 << AW); i++) begin
      rd_addr = AW'(i);
      @(posedge clk); #1;
      exp = (i < expLen) ? expPath[i] : '0;
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL %s_read%0d: got %h, expected %h", name, i, rd_data, exp);
      end
    end
  endtask

  task automatic test_paths();
    runWalk(fillGrid(2'b10), "corner"); dropGrid("corner"); checkReads("corner");
    runWalk(fillGrid(2'b00), "top");    dropGrid("top");    checkReads("top");
    runWalk(fillGrid(2'b01), "left");
    checkReads("left");
    dropGrid("left");
  endtask

  task automatic test_illegal_code();
    logic [2*L*L-1:0] g;
    g = fillGrid(2'b10);
    g[(2*L + 2)*2 +: 2] = 2'b11;
    runWalk(g, "illegal");
    dropGrid("illegal");
    checkReads("illegal");
  endtask

  task automatic test_reset_midwalk();
    rd_addr = '0;
    directions = fillGrid(2'b00);
    grid_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wen !== 1'b1 || waddr !== AW'(1)) begin
      errors++;
      $display("[TB] FAIL midwalk_pre: got wen=%b waddr=%0d, expected wen=1 waddr=1", wen, waddr);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({wen, waddr, wdata, rd_data, path_len, busy, done, error} !== '0) begin
      errors++;
      $display("[TB] FAIL midwalk_reset: got wen=%b waddr=%0d wdata=%h rd=%h len=%0d busy=%b done=%b err=%b, expected all 0",
               wen, waddr, wdata, rd_data, path_len, busy, done, error);
    end
    reset = 1'b0;
    runWalk(fillGrid(2'b00), "restart");
  endtask

  task automatic test_back_to_back();
    int wenSeen = 0;
    int doneLow = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (wen) wenSeen++;
      if (!done) doneLow++;
    end
    checks++;
    if (wenSeen != 0 || doneLow != 0) begin
      errors++;
      $display("[TB] FAIL hold_high: got wen_cycles=%0d done_low_cycles=%0d, expected 0 and 0", wenSeen, doneLow);
    end
    dropGrid("hold");
    runWalk(fillGrid(2'b10), "second");
    dropGrid("second");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      runWalk(randGrid(), $sformatf("rand%0d", r));
      dropGrid($sformatf("rand%0d", r));
      if (r < 2) checkReads($sformatf("rand%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_paths();
    test_illegal_code();
    test_reset_midwalk();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
